// File: rtl/fp16_round_pack.sv
// FP16 adder output stage: round-to-nearest-even, overflow saturation, pack.
// One round register (S1) feeding a 2-entry output FIFO.
module fp16_round_pack #(
    parameter bit          ROUND_EN = 1'b1,
    parameter int unsigned MAX_EXP  = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [15:0] in_mant,
    input  logic [5:0]  in_exp,
    input  logic [1:0]  in_exc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [2:0]  out_flags
);

    localparam logic [6:0] MAXE = 7'(MAX_EXP);

    logic        s1_valid;
    logic        s1_sign;
    logic [12:0] s1_mant;
    logic [5:0]  s1_exp;
    logic [1:0]  s1_exc;

    logic [18:0] mem [2];
    logic        wptr;
    logic        rptr;
    logic [1:0]  cnt;

    logic        push;
    logic        pop;
    logic        full;
    logic        unused_mant;

    assign unused_mant = ^in_mant[15:13];

    assign full      = (cnt == 2'd2);
    assign in_ready  = !s1_valid || !full;
    assign push      = s1_valid && !full;
    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_exc   <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_sign  <= in_sign;
            s1_mant  <= in_mant[12:0];
            s1_exp   <= in_exp;
            s1_exc   <= in_exc;
        end else if (push) begin
            s1_valid <= 1'b0;
        end
    end

    logic [9:0]  f;
    logic        g;
    logic        s;
    logic        up;
    logic [10:0] sum;
    logic [6:0]  rexp;
    logic [9:0]  frac;
    logic [15:0] res;
    logic [2:0]  flg;

    assign f    = s1_mant[11:2];
    assign g    = s1_mant[1];
    assign s    = s1_mant[0];
    assign up   = ROUND_EN & g & (s | f[0]);
    assign sum  = {1'b0, f} + {10'b0, up};
    assign rexp = {1'b0, s1_exp} + {6'b0, sum[10]};
    assign frac = sum[10] ? 10'd0 : sum[9:0];

    // Priority: external overflow, underflow/zero, rounded overflow, normal.
    always_comb begin
        res = '0;
        flg = '0;
        if (s1_exc == 2'b01) begin
            res = {s1_sign, 5'h1F, 10'h0};
            flg = 3'b100;
        end else if (s1_exp == 6'd0) begin
            res = {s1_sign, 15'h0};
            flg = {1'b0, (s1_mant != 13'd0), 1'b1};
        end else if (rexp > MAXE) begin
            res = {s1_sign, 5'h1F, 10'h0};
            flg = 3'b110;
        end else begin
            res = {s1_sign, rexp[4:0], frac};
            flg = {1'b0, g | s, 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {res, flg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign out_result = out_valid ? mem[rptr][18:3] : 16'h0;
    assign out_flags  = out_valid ? mem[rptr][2:0]  : 3'b000;

endmodule
